// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared types and encodings for the multi-cycle control FSM
package control_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_TRAP
  } state_e;

  typedef enum logic [1:0] {
    FMT_I,
    FMT_S,
    FMT_B
  } imm_fmt_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational sign-extended immediate for I/S/B formats
module imm_gen
  import control_pkg::*;
(
  input  logic [31:0] ir,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{20{ir[31]}}, ir[31:20]};
      FMT_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      FMT_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK control with sticky TRAP
module control_fsm
  import control_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        eq,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic [2:0]  ALUctrl,
  output logic        ALUsrc,
  output logic        regWrite,
  output logic        resultSrc,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        pc_en,
  output logic        pcSrc,
  output logic        illegal,
  output logic [31:0] instret
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] instret_q, instret_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_lw, is_sw, is_br, legal;
  imm_fmt_e    fmt;

  assign opcode  = ir_q[6:0];
  assign funct3  = ir_q[14:12];
  assign rd      = ir_q[11:7];
  assign rs1     = ir_q[19:15];
  assign rs2     = ir_q[24:20];
  assign illegal = (state_q == S_TRAP);
  assign instret = instret_q;

  imm_gen u_imm_gen (
    .ir  (ir_q),
    .fmt (fmt),
    .imm (imm)
  );

  // Decode is purely a function of IR, so the fields stay stable from DECODE onward.
  always_comb begin
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_br   = 1'b0;
    legal   = 1'b0;
    ALUctrl = ALU_ADD;
    ALUsrc  = 1'b0;
    fmt     = FMT_I;
    case (opcode)
      OP_R: begin
        legal = 1'b1;
        case (funct3)
          F3_ADD_SUB: ALUctrl = ir_q[30] ? ALU_SUB : ALU_ADD;
          F3_AND:     ALUctrl = ALU_AND;
          F3_OR:      ALUctrl = ALU_OR;
          F3_SLT:     ALUctrl = ALU_SLT;
          default:    legal   = 1'b0;
        endcase
      end
      OP_ADDI: begin
        ALUsrc = 1'b1;
        legal  = (funct3 == F3_ADDI);
      end
      OP_LOAD: begin
        is_lw  = 1'b1;
        ALUsrc = 1'b1;
        legal  = (funct3 == F3_LW);
      end
      OP_STORE: begin
        is_sw  = 1'b1;
        ALUsrc = 1'b1;
        fmt    = FMT_S;
        legal  = (funct3 == F3_SW);
      end
      OP_BRANCH: begin
        is_br   = 1'b1;
        ALUctrl = ALU_SUB;
        fmt     = FMT_B;
        legal   = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    instret_d   = instret_q;
    instr_ready = 1'b0;
    regWrite    = 1'b0;
    resultSrc   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    pc_en       = 1'b0;
    pcSrc       = 1'b0;
    case (state_q)
      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE: begin
        if (is_br) begin
          pc_en   = 1'b1;
          pcSrc   = (funct3 == F3_BNE) ? !eq : eq;
          state_d = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      // Request is combinational from state so an async reset drops it immediately.
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_sw;
        if (mem_ack) begin
          if (is_sw) begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        regWrite  = (rd != 5'd0);
        resultSrc = is_lw;
        pc_en     = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    if (pc_en) instret_d = instret_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ir_q      <= NOP_INSTR;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// tb/tb_control_fsm.sv - randomized self-checking bench for control_fsm against an ISA-level model
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        eq = 1'b0;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic [2:0]  ALUctrl;
  logic        ALUsrc, regWrite, resultSrc, mem_req, mem_we;
  logic        mem_ack = 1'b0;
  logic        pc_en, pcSrc, illegal;
  logic [31:0] instret;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_instret = '0;

  localparam int C_R = 0, C_ADDI = 1, C_LW = 2, C_SW = 3, C_BR = 4, C_ILL = 5;

  control_fsm dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .eq(eq), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc),
    .regWrite(regWrite), .resultSrc(resultSrc), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .pc_en(pc_en), .pcSrc(pcSrc), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  function automatic int classify(input logic [31:0] ins);
    int op = int'(ins[6:0]);
    int f3 = int'(ins[14:12]);
    if (op == 'h33 && (f3 == 0 || f3 == 2 || f3 == 6 || f3 == 7)) return C_R;
    if (op == 'h13 && f3 == 0) return C_ADDI;
    if (op == 'h03 && f3 == 2) return C_LW;
    if (op == 'h23 && f3 == 2) return C_SW;
    if (op == 'h63 && (f3 == 0 || f3 == 1)) return C_BR;
    return C_ILL;
  endfunction

  function automatic logic [2:0] model_alu(input logic [31:0] ins, input int cls);
    if (cls == C_BR) return 3'd1;
    if (cls != C_R) return 3'd0;
    case (int'(ins[14:12]))
      0: return ins[30] ? 3'd1 : 3'd0;
      7: return 3'd2;
      6: return 3'd3;
      default: return 3'd5;
    endcase
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] ins, input int cls);
    int v;
    if (cls == C_SW)      v = int'({ins[31:25], ins[11:7]});
    else if (cls == C_BR) v = int'({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2;
    else                  v = int'(ins[31:20]);
    if (cls == C_BR) begin
      if (v >= 4096) v = v - 8192;
    end else if (v >= 2048) begin
      v = v - 4096;
    end
    return 32'(v);
  endfunction

  task automatic gen_legal(output logic [31:0] ins);
    logic [4:0]  r1, r2, rdv;
    logic [11:0] im;
    logic [2:0]  f3;
    r1 = 5'($urandom); r2 = 5'($urandom); rdv = 5'($urandom); im = 12'($urandom);
    if ($urandom_range(0, 5) == 0) rdv = 5'd0;
    case ($urandom_range(0, 4))
      0: begin
        case ($urandom_range(0, 3))
          0: f3 = 3'b000;
          1: f3 = 3'b111;
          2: f3 = 3'b110;
          default: f3 = 3'b010;
        endcase
        ins = {1'b0, 1'($urandom), 5'b0, r2, r1, f3, rdv, 7'h33};
      end
      1: ins = {im, r1, 3'b000, rdv, 7'h13};
      2: ins = {im, r1, 3'b010, rdv, 7'h03};
      3: ins = {im[11:5], r2, r1, 3'b010, im[4:0], 7'h23};
      default: ins = {im[11:5], r2, r1, 2'b00, 1'($urandom), im[4:0], 7'h63};
    endcase
  endtask

  task automatic run_instr(input logic [31:0] ins, input int n_wait, input logic eq_v, input string name);
    int cls = classify(ins);
    int lat;
    int pc_cnt = 0, pc_cyc = -1, rw_cnt = 0, rw_cyc = -1, mr_cnt = 0;
    int we_bad = 0, idle_src_bad = 0, rdy_bad = 0;
    int exp_rw, exp_mr;
    logic pcsrc_at = 1'b0, rsrc_at = 1'b0, exp_pcsrc;
    logic [4:0] s_rs1 = '0, s_rs2 = '0, s_rd = '0;
    logic [2:0] s_alu = '0;
    logic s_alusrc = 1'b0;
    logic [31:0] s_imm = '0;
    logic is_mem;
    case (cls)
      C_BR:    lat = 3;
      C_SW:    lat = 4 + n_wait;
      C_LW:    lat = 5 + n_wait;
      default: lat = 4;
    endcase
    is_mem = (cls == C_LW || cls == C_SW);
    @(negedge clk);
    instr = ins; instr_valid = 1'b1; eq = eq_v; mem_ack = 1'b0;
    #1;
    n_checks++;
    if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL %s accept: instr_ready=%b want 1", name, instr_ready); end
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      instr_valid = (k < lat) ? 1'($urandom) : 1'b0;
      instr = $urandom;
      if (is_mem) mem_ack = (k == 3 + n_wait) || (k < 3 && 1'($urandom));
      else        mem_ack = (k < lat) ? 1'($urandom) : 1'b0;
      #1;
      if (k == lat) begin
        n_checks++;
        if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL %s return_to_fetch: instr_ready=%b want 1", name, instr_ready); end
      end else begin
        if (pc_en === 1'b1) begin pc_cnt++; pc_cyc = k; pcsrc_at = pcSrc; end
        else if (pcSrc !== 1'b0) idle_src_bad++;
        if (regWrite === 1'b1) begin rw_cnt++; rw_cyc = k; rsrc_at = resultSrc; end
        if (mem_req === 1'b1) begin mr_cnt++; if (mem_we !== (cls == C_SW)) we_bad++; end
        else if (mem_we !== 1'b0) we_bad++;
        if (instr_ready !== 1'b0) rdy_bad++;
        if (k == 2) begin
          s_rs1 = rs1; s_rs2 = rs2; s_rd = rd; s_alu = ALUctrl; s_alusrc = ALUsrc; s_imm = imm;
        end
      end
    end
    instr_valid = 1'b0; mem_ack = 1'b0;
    exp_instret = exp_instret + 32'd1;
    exp_rw = ((cls == C_R || cls == C_ADDI || cls == C_LW) && ins[11:7] != 5'd0) ? 1 : 0;
    exp_mr = is_mem ? n_wait + 1 : 0;
    exp_pcsrc = (cls == C_BR) ? (ins[12] ? !eq_v : eq_v) : 1'b0;
    n_checks += 12;
    if (pc_cnt != 1 || pc_cyc != lat - 1) begin n_fail++; $display("FAIL %s pc_en: %0d pulses at cycle %0d want 1 at %0d", name, pc_cnt, pc_cyc, lat - 1); end
    if (pcsrc_at !== exp_pcsrc) begin n_fail++; $display("FAIL %s pcSrc: got %b want %b", name, pcsrc_at, exp_pcsrc); end
    if (idle_src_bad != 0) begin n_fail++; $display("FAIL %s pcSrc_idle: %0d cycles high without pc_en want 0", name, idle_src_bad); end
    if (rw_cnt != exp_rw || (exp_rw == 1 && rw_cyc != lat - 1)) begin n_fail++; $display("FAIL %s regWrite: %0d pulses at %0d want %0d at %0d", name, rw_cnt, rw_cyc, exp_rw, lat - 1); end
    if (exp_rw == 1 && rsrc_at !== (cls == C_LW)) begin n_fail++; $display("FAIL %s resultSrc: got %b want %b", name, rsrc_at, cls == C_LW); end
    if (mr_cnt != exp_mr || we_bad != 0) begin n_fail++; $display("FAIL %s mem_req: %0d cycles (we errors %0d) want %0d (0)", name, mr_cnt, we_bad, exp_mr); end
    if (rdy_bad != 0) begin n_fail++; $display("FAIL %s busy_ready: %0d cycles ready while busy want 0", name, rdy_bad); end
    if (s_rs1 !== ins[19:15] || s_rs2 !== ins[24:20]) begin n_fail++; $display("FAIL %s rs: got %0d,%0d want %0d,%0d", name, s_rs1, s_rs2, ins[19:15], ins[24:20]); end
    if (s_rd !== ins[11:7]) begin n_fail++; $display("FAIL %s rd: got %0d want %0d", name, s_rd, ins[11:7]); end
    if (s_alu !== model_alu(ins, cls) || s_alusrc !== (cls == C_ADDI || is_mem)) begin n_fail++; $display("FAIL %s alu: ctrl=%b src=%b want ctrl=%b src=%b", name, s_alu, s_alusrc, model_alu(ins, cls), cls == C_ADDI || is_mem); end
    if (cls != C_R && s_imm !== model_imm(ins, cls)) begin n_fail++; $display("FAIL %s imm: got %h want %h", name, s_imm, model_imm(ins, cls)); end
    if (instret !== exp_instret) begin n_fail++; $display("FAIL %s instret: got %0d want %0d", name, instret, exp_instret); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_checks += 4;
    if (instr_ready !== 1'b1 || illegal !== 1'b0) begin n_fail++; $display("FAIL reset_state: ready=%b illegal=%b want 1 0", instr_ready, illegal); end
    if (instret !== 32'd0) begin n_fail++; $display("FAIL reset_instret: got %0d want 0", instret); end
    if ({regWrite, mem_req, mem_we, pc_en, pcSrc} !== 5'b0) begin n_fail++; $display("FAIL reset_strobes: got %b want 00000", {regWrite, mem_req, mem_we, pc_en, pcSrc}); end
    if (rd !== 5'd0 || rs1 !== 5'd0 || imm !== 32'd0 || ALUsrc !== 1'b1) begin n_fail++; $display("FAIL reset_ir_nop: rd=%0d rs1=%0d imm=%h alusrc=%b want 0 0 0 1", rd, rs1, imm, ALUsrc); end
    @(negedge clk);
    rst = 1'b0;
    exp_instret = '0;
  endtask

  task automatic test_trap(input logic [31:0] ins, input string name);
    int bad = 0;
    @(negedge clk);
    instr = ins; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    for (int k = 2; k < 22; k++) begin
      @(negedge clk);
      instr_valid = 1'($urandom); instr = $urandom; mem_ack = 1'($urandom);
      #1;
      if (illegal !== 1'b1 || instr_ready !== 1'b0 || {regWrite, mem_req, pc_en} !== 3'b0) bad++;
    end
    instr_valid = 1'b0; mem_ack = 1'b0;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL %s trap_hold: %0d bad cycles want 0", name, bad); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (illegal !== 1'b0 || instret !== 32'd0 || instr_ready !== 1'b1) begin n_fail++; $display("FAIL %s trap_reset: illegal=%b instret=%0d ready=%b want 0 0 1", name, illegal, instret, instr_ready); end
    @(negedge clk);
    rst = 1'b0;
    exp_instret = '0;
  endtask

  task automatic test_reset_mid_mem();
    @(negedge clk);
    instr = 32'h0020_A223; instr_valid = 1'b1; mem_ack = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      instr_valid = 1'b0;
    end
    #1;
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL sw_mem_entry: mem_req=%b mem_we=%b want 1 1", mem_req, mem_we); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || pc_en !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mid_mem: mem_req=%b pc_en=%b mem_we=%b want 0 0 0", mem_req, pc_en, mem_we); end
    @(negedge clk);
    rst = 1'b0;
    exp_instret = '0;
    n_checks++;
    if (instret !== 32'd0) begin n_fail++; $display("FAIL rst_mid_mem_instret: got %0d want 0", instret); end
  endtask

  task automatic test_random(input int count);
    logic [31:0] ins;
    for (int i = 0; i < count; i++) begin
      gen_legal(ins);
      run_instr(ins, $urandom_range(0, 4), 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    run_instr(32'h0050_0093, 0, 1'b0, "addi");
    run_instr(32'h0020_81B3, 0, 1'b0, "add");
    run_instr(32'h4020_81B3, 0, 1'b0, "sub");
    run_instr(32'h0020_8463, 0, 1'b1, "beq_taken");
    run_instr(32'h0020_8463, 0, 1'b0, "beq_not_taken");
    run_instr(32'h0020_9463, 0, 1'b0, "bne_taken");
    run_instr(32'h0040_A283, 2, 1'b0, "lw_wait");
    run_instr(32'h0040_A003, 0, 1'b0, "lw_rd0");
    run_instr(32'h0020_A223, 0, 1'b0, "sw_nowait");
    run_instr(32'h0020_A223, 3, 1'b0, "sw_wait");
    test_random(40);
    test_trap(32'hFFFF_FFFF, "ill_ffff");
    test_trap(32'h0010_9093, "ill_addi_f3");
    test_trap(32'h0020_C463, "ill_branch_f3");
    test_trap(32'h1234_5037, "ill_lui");
    test_reset_mid_mem();
    run_instr(32'h0050_0093, 0, 1'b0, "after_rst_mem");
    test_random(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising-edge; rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have instr  in  32  instruction word from fetch; instr_valid  in  1  instr present; instr_ready  out  1  FSM accepts instr.
REQ-003 SHALL have eq  in  1  datapath ALU zero/equal flag, sampled in EXECUTE only.
REQ-004 SHALL have rs1, rs2, rd  out  5 each  register addresses, taken straight from IR fields.
REQ-005 SHALL have imm  out  32  sign-extended immediate (I/S/B formats).
REQ-006 SHALL have the following datapath controls: ALUctrl  out  3; ALUsrc  out  1 (1 = imm); regWrite  out  1; resultSrc  out  1 (1 = memory data).
REQ-007 SHALL have mem_req  out  1; mem_we  out  1; mem_ack  in  1.
REQ-008 SHALL have pc_en  out  1 (retire pulse); pcSrc  out  1 (1 = branch taken); illegal  out  1; instret  out  32.

Function
REQ-009 SHALL implement states FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
REQ-010 In FETCH, instr_ready SHALL be 1; when instr_valid&&instr_ready, instr SHALL be loaded into IR and the state SHALL go to DECODE; otherwise the FSM holds.
REQ-011 DECODE SHALL classify the opcode:
- 0110011 R (ADD/SUB/AND/OR/SLT)
- 0010011 ADDI
- 0000011 LW
- 0100011 SW
- 1100011 BEQ/BNE
REQ-012 Any other opcode or funct3 SHALL go to TRAP; from DECODE, all others go to EXECUTE.
REQ-013 ALUctrl encoding SHALL be 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-014 SUB SHALL be selected by funct7[5]=1 on R-type with funct3=000; ADDI/LW/SW SHALL use add; branches SHALL use sub.
REQ-015 In EXECUTE, ALUctrl and ALUsrc SHALL be valid. Next state SHALL be:
- R/ADDI -> WRITEBACK
- LW/SW -> MEM
- branch -> FETCH
REQ-016 For a branch in EXECUTE, pc_en SHALL be 1 for that cycle, and pcSrc SHALL be eq (BEQ) or !eq (BNE).
REQ-017 In MEM, mem_req SHALL be held at 1 until mem_ack, and mem_we SHALL be 1 only for SW. On ack: LW -> WRITEBACK; SW -> FETCH with pc_en pulse.
REQ-018 In WRITEBACK, regWrite SHALL be 1 for exactly one cycle, except 0 when rd==0; resultSrc SHALL be 1 for LW; pc_en SHALL be 1; next state FETCH.
REQ-019 pc_en SHALL pulse exactly once per retired instruction, and pcSrc SHALL be 0 whenever pc_en=0.
REQ-020 instret SHALL increment on every pc_en cycle and wrap from 0xFFFFFFFF to 0.
REQ-021 Latency from instr accept SHALL be:
- branch: 3 cycles
- R/ADDI: 4 cycles
- SW: 4+N cycles
- LW: 5+N cycles
where N = cycles spent waiting for mem_ack.
REQ-022 TRAP SHALL be sticky until rst; in TRAP, illegal=1 and all strobes (regWrite, mem_req, pc_en, instr_ready) SHALL be 0.
REQ-023 mem_ack outside MEM SHALL be ignored; instr_valid outside FETCH SHALL be ignored.

Reset
REQ-024 On rst=1, the FSM SHALL asynchronously enter FETCH and clear instret and illegal.
REQ-025 On rst=1, IR SHALL be set to 0x00000013 (NOP).
REQ-026 On rst=1, regWrite, mem_req, mem_we, pc_en and pcSrc SHALL be 0.
REQ-027 rst mid-MEM SHALL drop mem_req in the same cycle, with no retire pulse.

Structure
REQ-028 control_pkg SHALL hold:
- the state enum
- opcode constants
- ALUctrl encodings
- funct3 constants
REQ-029 Immediate generation SHALL be a sub-module imm_gen, combinational, with inputs IR and format select, and output imm.

Verification
REQ-030 addi x1,x0,5 (0x00500093), valid at cycle 0:
- rd=1, ALUsrc=1, imm=5, ALUctrl=000
- regWrite=1 and pc_en=1 at cycle 3
- instret=1
REQ-031 add x3,x1,x2 (0x002081B3):
- rs1=1, rs2=2, rd=3, ALUctrl=000, ALUsrc=0
- single regWrite pulse
- then sub variant 0x402081B3 -> ALUctrl=001
REQ-032 beq x1,x2,8 (0x00208463), run twice:
- eq=1 -> pc_en=1, pcSrc=1, imm=8 at cycle 2
- eq=0 -> pcSrc=0
- regWrite never asserted
REQ-033 lw x5,4(x1) (0x0040A283), mem_ack delayed 3 cycles:
- mem_req held 3 cycles, mem_we=0
- then WRITEBACK with resultSrc=1, regWrite=1, rd=5
REQ-034 Illegal 0xFFFFFFFF:
- illegal=1 and instr_ready=0 held for 20 cycles
- rst pulse -> FETCH, illegal=0, instret=0
REQ-035 rst during MEM of SW:
- mem_req=0 immediately, no pc_en
- next instr accepted normally
